// File: rtl/pixel_readout_pkg.sv
// Shared types and constants for the pixel readout sequencer.
package pixel_readout_pkg;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 16;

   localparam logic [1:0] WT_HDR = 2'b10;
   localparam logic [1:0] WT_HIT = 2'b01;
   localparam logic [1:0] WT_TRL = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      HEADER,
      SCAN,
      TRAILER,
      END
   } state_t;

endpackage

// File: rtl/readout_fifo.sv
// Synchronous show-ahead FIFO; the head word is presented combinationally while not empty.
module readout_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_wrEn,
   input  logic [WIDTH-1:0] i_wrData,
   input  logic             i_rdEn,
   output logic [WIDTH-1:0] o_rdData,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   // A full FIFO refuses the write even if the head is popped in the same cycle.
   assign w_push = i_wrEn & ~o_full;
   assign w_pop  = i_rdEn & ~o_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wrPtr] <= i_wrData;
   end

   assign o_full   = (r_count == (AW+1)'(DEPTH));
   assign o_empty  = (r_count == '0);
   assign o_rdData = o_empty ? '0 : r_mem[r_rdPtr];

endmodule

// File: rtl/pixel_readout_ctrl.sv
// Frame readout sequencer: drains the pixel priority encoder into a header/hit/trailer word stream.
// Optional trailer word with overflow flag is built when PIXEL_READOUT_TRAILER_EN is defined.
module pixel_readout_ctrl
   import pixel_readout_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int MAX_HITS   = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              trigger,
   output logic              busy,
   input  logic              enc_valid,
   input  logic [ADDR_W-1:0] enc_addr,
   output logic              enc_read,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam logic [7:0] CAP = 8'(MAX_HITS);

   state_t              r_state;
   state_t              w_nextState;
   logic [7:0]          r_frameId;
   logic [7:0]          r_hitCnt;
   logic                w_wrEn;
   logic [DATA_W-1:0]   w_wrData;
   logic                w_full;
   logic                w_empty;
   logic                w_capHit;
   logic                w_encRead;

   assign w_capHit = (r_hitCnt >= CAP);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_frameId <= '0;
         r_hitCnt  <= '0;
      end else begin
         r_state <= w_nextState;
         if (w_encRead) r_hitCnt <= r_hitCnt + 1'b1;
         if (r_state == END) begin
            r_frameId <= r_frameId + 1'b1;
            r_hitCnt  <= '0;
         end
      end
   end

`ifdef PIXEL_READOUT_TRAILER_EN
   logic r_ovf;

   // Overflow means the cap stopped the scan while hits were still pending.
   always_ff @(posedge clk) begin
      if (reset || r_state == END) begin
         r_ovf <= 1'b0;
      end else if (r_state == SCAN && enc_valid && w_capHit) begin
         r_ovf <= 1'b1;
      end
   end
`endif

   always_comb begin
      w_nextState = r_state;
      w_wrEn      = 1'b0;
      w_wrData    = '0;
      w_encRead   = 1'b0;
      case (r_state)
         IDLE: begin
            if (trigger) w_nextState = HEADER;
         end
         HEADER: begin
            if (!w_full) begin
               w_wrEn      = 1'b1;
               w_wrData    = {WT_HDR, 6'b0, r_frameId};
               w_nextState = SCAN;
            end
         end
         SCAN: begin
            w_encRead = enc_valid & ~w_full & ~w_capHit;
            if (w_encRead) begin
               w_wrEn   = 1'b1;
               w_wrData = {WT_HIT, 7'b0, enc_addr};
            end
            if (!enc_valid || w_capHit) begin
`ifdef PIXEL_READOUT_TRAILER_EN
               w_nextState = TRAILER;
`else
               w_nextState = END;
`endif
            end
         end
         TRAILER: begin
`ifdef PIXEL_READOUT_TRAILER_EN
            if (!w_full) begin
               w_wrEn      = 1'b1;
               w_wrData    = {WT_TRL, r_ovf, 5'b0, r_hitCnt};
               w_nextState = END;
            end
`else
            w_nextState = END;
`endif
         end
         END: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Masking the strobe during reset keeps an aborted frame from consuming a pixel hit.
   assign enc_read  = w_encRead & ~reset;
   assign busy      = (r_state != IDLE);
   assign out_valid = ~w_empty;

   readout_fifo #(
      .DEPTH(FIFO_DEPTH),
      .WIDTH(DATA_W)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .i_wrEn   (w_wrEn),
      .i_wrData (w_wrData),
      .i_rdEn   (out_ready),
      .o_rdData (out_data),
      .o_full   (w_full),
      .o_empty  (w_empty)
   );

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Self-checking bench for pixel_readout_ctrl with a behavioural pixel encoder and frame model.
module tb_pixel_readout_ctrl;

   localparam int FIFO_DEPTH = 8;
   localparam int MAX_HITS   = 24;

   logic        clk;
   logic        reset;
   logic        trigger;
   logic        busy;
   logic        enc_valid;
   logic [6:0]  enc_addr;
   logic        enc_read;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;

   logic [127:0] pixels;
   logic [127:0] expRemain;
   logic [15:0]  expQ[$];
   logic [15:0]  gotQ[$];
   int           readCyc[$];
   int           expReads;
   int           readCnt;
   int           cycNum;
   int           checks;
   int           errors;
   logic [7:0]   modelFid;

   pixel_readout_ctrl #(
      .FIFO_DEPTH(FIFO_DEPTH),
      .MAX_HITS  (MAX_HITS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .trigger   (trigger),
      .busy      (busy),
      .enc_valid (enc_valid),
      .enc_addr  (enc_addr),
      .enc_read  (enc_read),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Priority encoder: lowest pending address wins.
   assign enc_valid = |pixels;
   always_comb begin
      enc_addr = '0;
      for (int i = 127; i >= 0; i--) begin
         if (pixels[i]) enc_addr = 7'(i);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      logic       doClr;
      logic [6:0] a;
      doClr = 1'b0;
      a     = '0;
      @(negedge clk);
      if (enc_read) begin
         doClr = 1'b1;
         a     = enc_addr;
         readCnt++;
         readCyc.push_back(cycNum);
      end
      if (out_valid && out_ready) gotQ.push_back(out_data);
      @(posedge clk);
      #1;
      cycNum++;
      if (doClr) pixels[a] = 1'b0;
   endtask

   // Expected frame: header, ascending addresses up to the cap, optional trailer.
   task automatic buildExpected(input logic [127:0] snap);
      int n;
      n = 0;
      expQ.delete();
      expQ.push_back({2'b10, 6'b0, modelFid});
      expRemain = snap;
      for (int a = 0; a < 128; a++) begin
         if (snap[a] && n < MAX_HITS) begin
            expQ.push_back({2'b01, 7'b0, 7'(a)});
            expRemain[a] = 1'b0;
            n++;
         end
      end
      expReads = n;
`ifdef PIXEL_READOUT_TRAILER_EN
      expQ.push_back({2'b11, (expRemain != '0), 5'b0, 8'(n)});
`endif
   endtask

   task automatic applyStimulus(input logic [127:0] hits);
      pixels = pixels | hits;
      buildExpected(pixels);
      readCnt = 0;
      readCyc.delete();
      gotQ.delete();
      trigger = 1'b1;
      cycle();
      trigger = 1'b0;
   endtask

   // mode 0: always ready, 1: random ready, 2: never ready
   task automatic waitIdle(input int mode);
      int guard;
      guard = 0;
      while ((busy || out_valid) && guard < 3000) begin
         out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom % 2) : 1'b0;
         cycle();
         guard++;
      end
      out_ready = 1'b1;
      checkOutput("frame_timeout", 32'(guard < 3000), 32'd1);
   endtask

   task automatic checkFrame(input string tag);
      int n;
      checkOutput({tag, "_words"}, 32'(gotQ.size()), 32'(expQ.size()));
      n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
      for (int i = 0; i < n; i++) checkOutput({tag, "_word"}, 32'(gotQ[i]), 32'(expQ[i]));
      checkOutput({tag, "_reads"}, 32'(readCnt), 32'(expReads));
      checkOutput({tag, "_remain_lo"}, expRemain[31:0] ^ pixels[31:0], 32'd0);
      checkOutput({tag, "_remain_hi"}, 32'(|(expRemain[127:32] ^ pixels[127:32])), 32'd0);
      modelFid = modelFid + 8'd1;
   endtask

   task automatic runFrame(input logic [127:0] hits, input int mode, input string tag);
      applyStimulus(hits);
      waitIdle(mode);
      checkFrame(tag);
   endtask

   function automatic logic [127:0] randomHits(input int maxN);
      logic [127:0] h;
      int           n;
      h = '0;
      n = $urandom_range(0, maxN);
      for (int i = 0; i < n; i++) h[$urandom_range(0, 127)] = 1'b1;
      return h;
   endfunction

   initial begin
      logic [127:0] h;
      int           g;
      checks    = 0;
      errors    = 0;
      cycNum    = 0;
      readCnt   = 0;
      modelFid  = 8'd0;
      pixels    = '0;
      reset     = 1'b1;
      trigger   = 1'b0;
      out_ready = 1'b1;
      repeat (3) cycle();
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_data", 32'(out_data), 32'd0);
      checkOutput("rst_enc_read", 32'(enc_read), 32'd0);
      reset = 1'b0;
      cycle();

      $display("[TB] single frame");
      h = '0;
      h[5] = 1'b1; h[77] = 1'b1; h[127] = 1'b1;
      applyStimulus(h);
      checkOutput("trig_busy", 32'(busy), 32'd1);
      checkOutput("trig_no_valid_yet", 32'(out_valid), 32'd0);
      cycle();
      checkOutput("hdr_valid", 32'(out_valid), 32'd1);
      checkOutput("hdr_data", 32'(out_data), 32'h8000);
      waitIdle(0);
      checkOutput("single_w1", 32'(gotQ.size() > 1 ? gotQ[1] : 16'h0), 32'h4005);
      checkOutput("single_w3", 32'(gotQ.size() > 3 ? gotQ[3] : 16'h0), 32'h407F);
      checkOutput("single_consec", 32'(readCyc.size() == 3 ? readCyc[2] - readCyc[0] : -1), 32'd2);
      checkFrame("single");

      $display("[TB] empty frame");
      applyStimulus('0);
`ifdef PIXEL_READOUT_TRAILER_EN
      for (int s = 1; s <= 4; s++) begin
         cycle();
         checkOutput("empty_busy", 32'(busy), 32'(s < 4));
      end
`else
      for (int s = 1; s <= 3; s++) begin
         cycle();
         checkOutput("empty_busy", 32'(busy), 32'(s < 3));
      end
`endif
      waitIdle(0);
      checkOutput("empty_hdr", 32'(gotQ.size() > 0 ? gotQ[0] : 16'h0), 32'h8001);
`ifdef PIXEL_READOUT_TRAILER_EN
      checkOutput("empty_trl", 32'(gotQ.size() > 1 ? gotQ[1] : 16'h0), 32'hC000);
`endif
      checkFrame("empty");

      $display("[TB] backpressure");
      h = '0;
      for (int i = 0; i < 20; i++) h[i * 6 + 1] = 1'b1;
      out_ready = 1'b0;
      applyStimulus(h);
      repeat (29) cycle();
      checkOutput("bp_reads_full", 32'(readCnt), 32'(FIFO_DEPTH - 1));
      checkOutput("bp_enc_read_low", 32'(enc_read), 32'd0);
      checkOutput("bp_head", 32'(out_data), 32'h8002);
      waitIdle(0);
      checkFrame("bp");

      $display("[TB] cap");
      h = '0;
      for (int i = 0; i < MAX_HITS + 3; i++) h[i * 4 + 2] = 1'b1;
      runFrame(h, 1, "cap");
      runFrame('0, 0, "cap_rest");

      $display("[TB] reset mid-scan");
      h = '0;
      for (int i = 0; i < 6; i++) h[i * 9 + 3] = 1'b1;
      applyStimulus(h);
      g = 0;
      while (readCnt < 2 && g < 100) begin
         cycle();
         g++;
      end
      checkOutput("rst_scan_reached", 32'(readCnt), 32'd2);
      reset = 1'b1;
      cycle();
      checkOutput("rst_scan_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_scan_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      cycle();
      modelFid = 8'd0;
      runFrame('0, 0, "after_rst");
      checkOutput("after_rst_hdr", 32'(gotQ.size() > 0 ? gotQ[0] : 16'h0), 32'h8000);

      $display("[TB] retrigger while busy");
      h = '0;
      for (int i = 0; i < 10; i++) h[i * 11] = 1'b1;
      applyStimulus(h);
      cycle();
      cycle();
      trigger = 1'b1;
      cycle();
      trigger = 1'b0;
      waitIdle(0);
      repeat (5) cycle();
      checkOutput("retrig_idle", 32'(busy), 32'd0);
      checkFrame("retrig");

      $display("[TB] random frames up to frame id wrap");
      g = 0;
      while (modelFid != 8'd255 && g < 300) begin
         runFrame(randomHits(30), int'($urandom % 2), "rand");
         g++;
      end
      runFrame(randomHits(5), 0, "fid255");
      checkOutput("fid255_hdr", 32'(gotQ.size() > 0 ? gotQ[0] : 16'h0), 32'h80FF);
      runFrame(randomHits(5), 1, "fid_wrap");
      checkOutput("fid_wrap_hdr", 32'(gotQ.size() > 0 ? gotQ[0] : 16'h0), 32'h8000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
